// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and flag bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_SLT = 3'b111
   } op_e;

   localparam int FLAGS_W = 4;
   localparam int FLG_Z   = 0;
   localparam int FLG_C   = 1;
   localparam int FLG_V   = 2;
   localparam int FLG_N   = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {N,V,C,Z} flags from a, b and opcode.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int SH_W = $clog2(WIDTH);
   localparam int MSB  = WIDTH - 1;

   logic [WIDTH:0]  sum_ext;
   logic [WIDTH:0]  diff_ext;
   logic [SH_W-1:0] sh_amt;
   logic            carry;
   logic            ovf;

   // The extra top bit captures carry-out for ADD and borrow for SUB.
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};
   assign sh_amt   = b[SH_W-1:0];

   always_comb begin
      // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      flags  = '0;
      case (op_e'(opcode))
         OP_ADD: begin
            result = sum_ext[WIDTH-1:0];
            carry  = sum_ext[WIDTH];
            ovf    = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
         end
         OP_SUB: begin
            result = diff_ext[WIDTH-1:0];
            carry  = diff_ext[WIDTH];
            ovf    = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHL:  result = a << sh_amt;
         OP_SHR:  result = a >> sh_amt;
         OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
      flags[FLG_Z] = (result == '0);
      flags[FLG_C] = carry;
      flags[FLG_V] = ovf;
      flags[FLG_N] = result[MSB];
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, backpressure and a
// count of results accepted downstream.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic [CNT_W-1:0] op_count
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic [3:0]       s2_flags_q, s2_flags_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             s2_adv;
   logic             s1_adv;
   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] core_result;
   logic [3:0]       core_flags;

   // Each stage moves when its successor is empty or draining, so a full
   // pipe can accept and emit in the same cycle.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_adv;
   assign in_ready = !s1_valid_q || s2_adv;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = s2_valid_q && out_ready;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (s1_a_q),
      .b      (s1_b_q),
      .opcode (s1_op_q),
      .result (core_result),
      .flags  (core_flags)
   );

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_op_d     = s1_op_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_flags_d  = s2_flags_q;
      op_count_d  = op_count_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
      end
      if (in_fire) begin
         s1_a_d  = a;
         s1_b_d  = b;
         s1_op_d = opcode;
      end
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_adv) begin
         s2_result_d = core_result;
         s2_flags_d  = core_flags;
      end
      if (out_fire) begin
         op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples its _d value from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_flags_q  <= '0;
         op_count_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_op_q     <= s1_op_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_flags_q  <= s2_flags_d;
         op_count_q  <= op_count_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign result    = s2_result_q;
   assign flags     = s2_flags_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8, CNT_W=4): directed and random beats
// checked against an arithmetic reference model.
module tb_alu_pipe;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [2:0]    opcode = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic [3:0]    flags;
   logic [CW-1:0] op_count;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flg;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   model_cnt = 0;
   int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

   alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flags are {negative, overflow, carry, zero}.
   function automatic exp_t ref_model(input int ua, input int ub, input int op);
      exp_t e;
      int   r, sa, sb;
      bit   c, v;
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      c = 1'b0;
      v = 1'b0;
      case (op)
         0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
         1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
         2: r = ua & ub;
         3: r = ua | ub;
         4: r = ua ^ ub;
         5: r = ua << (ub % 8);
         6: r = ua >> (ub % 8);
         default: r = (sa < sb) ? 1 : 0;
      endcase
      r = r & 255;
      e.res = r[7:0];
      e.flg = {r[7], v, c, (r == 0)};
      return e;
   endfunction

   task automatic step();
      @(negedge clk);
      if (ready_mode == 2) out_ready = ($urandom % 4) != 0;
      else                 out_ready = (ready_mode == 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         in_valid = 1'b0;
      end
   endtask

   task automatic send(input int ua, input int ub, input int op, output int waits);
      bit done;
      done = 1'b0;
      waits = 0;
      step();
      in_valid = 1'b1;
      a = ua[W-1:0];
      b = ub[W-1:0];
      opcode = op[2:0];
      while (!done) begin
         #1;
         if (in_ready) begin
            sb_q.push_back(ref_model(ua, ub, op));
            done = 1'b1;
         end else if (waits >= 200) begin
            check("send_timeout", 32'd0, 32'd1);
            done = 1'b1;
         end else begin
            waits++;
            step();
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      model_cnt = 0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_op_count", op_count, 0);
      check("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops and compares on every output transfer, checks hold under stall.
   initial begin : monitor
      exp_t         e;
      bit           prev_stall;
      logic [W-1:0] prev_res;
      logic [3:0]   prev_flg;
      prev_stall = 1'b0;
      prev_res = '0;
      prev_flg = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_stall = 1'b0;
            continue;
         end
         check("op_count", op_count, model_cnt & 15);
         if (prev_stall) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_result", result, prev_res);
            check("hold_flags", flags, prev_flg);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_output", result, 32'hDEAD_0000);
            end else begin
               e = sb_q.pop_front();
               check("result", result, e.res);
               check("flags", flags, e.flg);
            end
            model_cnt++;
         end
         prev_stall = out_valid && !out_ready;
         prev_res = result;
         prev_flg = flags;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int w;
      int total_w;
      int budget;

      // Power-on reset state.
      #1;
      check("por_out_valid", out_valid, 1'b0);
      check("por_result", result, 0);
      check("por_flags", flags, 0);
      check("por_op_count", op_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("por_in_ready", in_ready, 1'b1);

      // Reset with two beats in flight: nothing must emerge afterwards.
      ready_mode = 0;
      send(1, 2, 0, w);
      send(3, 4, 0, w);
      do_reset();
      ready_mode = 1;
      idle(5);
      #1;
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);

      // Latency: output visible two cycles after the handshake cycle.
      send(10, 5, 0, w);
      idle(1);
      #1;
      check("lat_cycle1_out_valid", out_valid, 1'b0);
      idle(1);
      #1;
      check("lat_cycle2_out_valid", out_valid, 1'b1);
      idle(2);

      // Directed ADD/SUB/shift/compare corners.
      send(200, 100, 0, w);
      send(8'h7F, 1, 0, w);
      send(20, 7, 1, w);
      send(7, 20, 1, w);
      send(8'h80, 1, 1, w);
      send(5, 5, 1, w);
      send(8'h81, 9, 5, w);
      send(8'h80, 7, 6, w);
      send(8'hFF, 8'h01, 7, w);
      send(8'h01, 8'hFF, 7, w);
      send(8'hF0, 8'h3C, 2, w);
      send(8'hF0, 8'h3C, 3, w);
      send(8'hF0, 8'h3C, 4, w);
      idle(4);

      // Backpressure: two beats fill the pipe, the third is refused until release.
      ready_mode = 0;
      send(1, 1, 0, w);
      check("bp_beat1_waits", w, 0);
      send(2, 2, 0, w);
      check("bp_beat2_waits", w, 0);
      step();
      in_valid = 1'b1;
      a = 8'd3;
      b = 8'd3;
      opcode = 3'd0;
      #1;
      check("bp_third_blocked", in_ready, 1'b0);
      step();
      #1;
      check("bp_third_still_blocked", in_ready, 1'b0);
      ready_mode = 1;
      step();
      #1;
      check("bp_third_released", in_ready, 1'b1);
      sb_q.push_back(ref_model(3, 3, 0));
      idle(5);
      check("bp_drained", sb_q.size(), 0);

      // Random traffic with random backpressure.
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), w);
         if ($urandom % 5 == 0) idle(1);
      end
      ready_mode = 1;
      budget = 0;
      while (sb_q.size() != 0 && budget < 50) begin
         idle(1);
         budget++;
      end
      check("rand_drained", sb_q.size(), 0);

      // Counter wrap at CNT_W=4 with full-rate streaming.
      do_reset();
      ready_mode = 1;
      total_w = 0;
      for (int i = 0; i < 17; i++) begin
         send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), w);
         total_w += w;
      end
      check("stream_no_stall", total_w, 0);
      idle(3);
      #3;
      check("stream_drained", sb_q.size(), 0);
      check("wrap_op_count", op_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
